// File: rtl/instr_queue_if.sv
// Handshake bundle between instruction fetch and decode for instr_queue.
// Fetch pushes instructions on the in_* side and decode pops them on the
// out_* side. The master modport is the environment driving the queue.
// The slave modport is the queue itself.
interface instr_queue_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, count, full, empty
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, count, full, empty
  );
endinterface

// File: rtl/instr_queue.sv
// instr_queue: first-word-fall-through instruction queue between fetch and
// decode. It has DEPTH entries, where DEPTH is a power of two and at least 2.
// Each entry holds an XLEN-bit instruction word and its PC.
//
// Flush discards every entry and wins over enqueue and dequeue in the same
// cycle. Reset discards every entry in the same way, but asynchronously.
// While the head is not valid, decode sees a NOP (0x00000013) at PC 0.
//
// Optional feature macro: IQ_BYPASS_EN.
// When it is defined, an instruction arriving at an empty queue is shown to
// decode in the same cycle. If decode also takes it, the instruction is never
// written. In the default build (macro undefined), nothing on the input side
// reaches the outputs combinationally, so the minimum latency is one cycle.
module instr_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  instr_queue_if.slave     q_io
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

  // Storage is deliberately left without reset: it is only read through head
  // while count is non-zero, and by then every read slot has been written.
  logic [XLEN-1:0] instrMem_q [DEPTH];
  logic [XLEN-1:0] pcMem_q    [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic isFull;
  logic isEmpty;
  logic inReady;
  logic outValid;
  logic bypassHit;
  logic handThrough;
  logic doEnq;
  logic doDeq;
  logic [XLEN-1:0] outInstr;
  logic [XLEN-1:0] outPc;

  // Occupancy flags and handshake qualifiers; reset and flush both close the ports
  always_comb begin
    isFull      = (count_q == CW'(DEPTH));
    isEmpty     = (count_q == '0);
`ifdef IQ_BYPASS_EN
    bypassHit   = isEmpty && q_io.in_valid && !q_io.flush && !rst;
`else
    bypassHit   = 1'b0;
`endif
    handThrough = bypassHit && q_io.out_ready;
    inReady     = !isFull && !q_io.flush && !rst;
    outValid    = (!isEmpty || bypassHit) && !q_io.flush && !rst;
    doEnq       = q_io.in_valid && inReady && !handThrough;
    doDeq       = outValid && q_io.out_ready && !isEmpty;
  end

  // Pointer and occupancy next-state; flush clears everything and suppresses both handshakes
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (q_io.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (doEnq) begin
        tail_d = tail_q + AW'(1);
      end
      if (doDeq) begin
        head_d = head_q + AW'(1);
      end
      case ({doEnq, doDeq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Head, tail and count registers, cleared immediately when reset rises
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Write the accepted instruction into the tail slot
  always_ff @(posedge clk) begin
    if (doEnq) begin
      instrMem_q[tail_q] <= q_io.in_instr;
      pcMem_q[tail_q]    <= q_io.in_pc;
    end
  end

  // Decode-facing data: head entry (or the incoming word when bypassing), else a NOP at PC 0
  always_comb begin
    outInstr = NOP_INSTR;
    outPc    = '0;
    if (outValid) begin
`ifdef IQ_BYPASS_EN
      if (isEmpty) begin
        outInstr = q_io.in_instr;
        outPc    = q_io.in_pc;
      end else begin
        outInstr = instrMem_q[head_q];
        outPc    = pcMem_q[head_q];
      end
`else
      outInstr = instrMem_q[head_q];
      outPc    = pcMem_q[head_q];
`endif
    end
  end

  assign q_io.in_ready  = inReady;
  assign q_io.out_valid = outValid;
  assign q_io.out_instr = outInstr;
  assign q_io.out_pc    = outPc;
  assign q_io.count     = count_q;
  assign q_io.full      = isFull;
  assign q_io.empty     = isEmpty;

endmodule

// File: tb/tb_instr_queue.sv
// Testbench for instr_queue.
// A driver issues the stimulus. After each accepted enqueue it pushes the
// expected entry into a scoreboard queue. An occupancy model, kept as a plain
// integer, predicts the handshake and status flags.
// A separate monitor compares the head data whenever the DUT presents
// out_valid. It pops the scoreboard when decode consumes that entry.
module tb_instr_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic clk = 1'b0;
  logic rst;

  instr_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

  instr_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk  (clk),
    .rst  (rst),
    .q_io (bus)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  entry_t      expQ[$];
  int          mCount;
  logic [31:0] nextPc;

  // Record one comparison and report it if the actual value differs from the expected one
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Predict whether the incoming word is shown to decode directly (bypass builds only)
  function automatic bit modelBypass();
`ifdef IQ_BYPASS_EN
    return (mCount == 0) && bus.in_valid && !bus.flush;
`else
    return 1'b0;
`endif
  endfunction

  // Compare handshake and status outputs against the occupancy model
  task automatic checkOutput();
    bit expIn;
    bit expOut;
    expIn  = (mCount < DEPTH) && !bus.flush;
    expOut = ((mCount > 0) || modelBypass()) && !bus.flush;
    check("in_ready",  64'(bus.in_ready),  64'(expIn));
    check("out_valid", 64'(bus.out_valid), 64'(expOut));
    check("count",     64'(bus.count),     64'(mCount));
    check("full",      64'(bus.full),      64'(mCount == DEPTH));
    check("empty",     64'(bus.empty),     64'(mCount == 0));
    if (!expOut) begin
      check("idle_instr", 64'(bus.out_instr), 64'(NOP));
      check("idle_pc",    64'(bus.out_pc),    64'(0));
    end
  endtask

  // Advance the model at the clock edge according to the queue rules
  task automatic updateModel();
    bit expIn;
    bit byp;
    bit enq;
    bit deq;
    expIn = (mCount < DEPTH) && !bus.flush;
    byp   = modelBypass();
    enq   = bus.in_valid && expIn;
    deq   = (mCount > 0) && !bus.flush && bus.out_ready;
    if (bus.flush) begin
      mCount = 0;
      expQ.delete();
    end else if (byp && bus.out_ready) begin
      nextPc += 32'd4;
    end else begin
      if (deq) mCount--;
      if (enq) begin
        expQ.push_back('{instr: bus.in_instr, pc: nextPc});
        mCount++;
        nextPc += 32'd4;
      end
    end
  endtask

  // Drive one cycle of inputs, check at the falling edge, update the model at the rising edge
  task automatic applyStimulus(input bit fl, input bit iv, input logic [31:0] instr, input bit ordy);
    bus.flush     = fl;
    bus.in_valid  = iv;
    bus.in_instr  = instr;
    bus.in_pc     = nextPc;
    bus.out_ready = ordy;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  // Scoreboard monitor: compare the presented head, and pop it when decode takes it
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid === 1'b1) begin
        if (expQ.size() == 0) begin
`ifdef IQ_BYPASS_EN
          check("bypass_instr", 64'(bus.out_instr), 64'(bus.in_instr));
          check("bypass_pc",    64'(bus.out_pc),    64'(bus.in_pc));
`else
          tests++;
          fails++;
          $display("[TB] FAIL scoreboard_empty: got out_valid=1 pc=%0h required no output", bus.out_pc);
`endif
        end else begin
          check("head_instr", 64'(bus.out_instr), 64'(expQ[0].instr));
          check("head_pc",    64'(bus.out_pc),    64'(expQ[0].pc));
          if (bus.out_ready) void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    mCount        = 0;
    nextPc        = 32'h0;

    #2;
    check("rst_count",     64'(bus.count),     64'(0));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_in_ready",  64'(bus.in_ready),  64'(0));
    check("rst_empty",     64'(bus.empty),     64'(1));
    check("rst_full",      64'(bus.full),      64'(0));
    check("rst_out_instr", 64'(bus.out_instr), 64'(NOP));
    check("rst_out_pc",    64'(bus.out_pc),    64'(0));

    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ignore_count", 64'(bus.count), 64'(0));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    rst = 1'b0;

    // Two entries held back, then drained in order
    applyStimulus(0, 1, 32'hAAA0_0093, 0);
    applyStimulus(0, 1, 32'hBBB0_0113, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 32'h0, 1);

    // Fill to full, then offer a fifth entry while decode drains
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, $urandom, 0);
    applyStimulus(0, 1, $urandom, 1);
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 32'h0, 1);

    // Continuous streaming across pointer wrap, PCs 0x0 to 0x24
    nextPc = 32'h0;
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, $urandom, 1);
    applyStimulus(0, 0, 32'h0, 1);

    // Flush with three entries queued and both handshakes requested
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, $urandom, 0);
    applyStimulus(1, 1, $urandom, 1);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 32'h0, 1);

    // Asynchronous reset mid-stream with two entries queued
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, $urandom, 0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_count",     64'(bus.count),     64'(0));
    check("async_rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("async_rst_empty",     64'(bus.empty),     64'(1));
    check("async_rst_out_instr", 64'(bus.out_instr), 64'(NOP));
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    mCount = 0;
    expQ.delete();
    #1;
    rst = 1'b0;

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
                    $urandom, ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(0, 0, 32'h0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
